// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bundle: redirect/halt control, imem request/response and decoder-facing head.
// master = the fetch queue, slave = its environment (memory + decoder).
interface inst_fetch_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             halt_in;
  logic             imem_req_valid;
  logic [XLEN-1:0]  imem_req_addr;
  logic             imem_req_ready;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             out_valid;
  logic [31:0]      out_inst;
  logic [XLEN-1:0]  out_pc;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  modport master (
    input  redirect_valid, redirect_pc, halt_in, imem_req_ready,
           imem_rsp_valid, imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, count
  );

  modport slave (
    output redirect_valid, redirect_pc, halt_in, imem_req_ready,
           imem_rsp_valid, imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetcher with one outstanding imem request and a PC-tagged FIFO
// feeding the decoder; redirect/halt flush the queue and squash any in-flight response.
module inst_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  inst_fetch_queue_if.master     bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]       state, state_d;
  logic [XLEN-1:0]  fetch_pc, fetch_pc_d;
  logic [XLEN-1:0]  req_pc, req_pc_d;
  logic             halted, halted_d;
  logic [PTR_W-1:0] head, head_d, tail, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      inst_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem   [DEPTH];

  logic flush, req_valid, fire, push, pop, not_empty;

  // Next-state, fetch PC and FIFO pointer logic
  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    req_pc_d   = req_pc;
    halted_d   = halted;
    head_d     = head;
    tail_d     = tail;
    count_d    = count_q;

    flush     = bus.redirect_valid || bus.halt_in;
    not_empty = (count_q != '0);
    req_valid = reset_n && (state == S_REQ) && !halted && !bus.redirect_valid
                && (count_q < CNT_W'(DEPTH));
    fire      = req_valid && bus.imem_req_ready;
    push      = (state == S_WAIT) && bus.imem_rsp_valid && !flush;
    pop       = not_empty && bus.out_ready && !flush;

    case (state)
      S_REQ: begin
        if (fire) begin
          req_pc_d = fetch_pc;
          // A request accepted in a halt cycle is already stale: squash its response.
          if (bus.halt_in) begin
            state_d = S_DISCARD;
          end else begin
            state_d    = S_WAIT;
            fetch_pc_d = fetch_pc + XLEN'(4);
          end
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) state_d = S_REQ;
        else if (flush)         state_d = S_DISCARD;
      end
      S_DISCARD: begin
        if (bus.imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
      halted_d   = 1'b0;
    end else if (bus.halt_in) begin
      halted_d = 1'b1;
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail + PTR_W'(1);
      if (pop)  head_d = head + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      halted   <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      req_pc   <= req_pc_d;
      halted   <= halted_d;
      head     <= head_d;
      tail     <= tail_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: reads are masked by count.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[tail] <= bus.imem_rsp_data;
      pc_mem[tail]   <= req_pc;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = reset_n ? fetch_pc : '0;
  assign bus.out_valid      = not_empty;
  assign bus.out_inst       = not_empty ? inst_mem[head] : '0;
  assign bus.out_pc         = not_empty ? pc_mem[head]   : '0;
  assign bus.count          = count_q;

  // Memory must only answer while a request is outstanding.
  rsp_in_window: assert property (@(posedge clock) disable iff (!reset_n)
    bus.imem_rsp_valid |-> (state == S_WAIT || state == S_DISCARD));
endmodule
